keccak_rho_pi_unit: RTL and testbench
=====================================

# keccak_rho_pi_unit

Parametrised, multi-cycle Keccak ρ/π step unit for the SHAKE datapath. It accepts a full 5×5 lane state over a valid/ready handshake and applies one of three modes: lane rotation (ρ), rotation followed by lane permutation (ρ+π), or inverse rotation (ρ⁻¹). It processes LPC lanes per cycle and holds the result until downstream accepts it. It sits between θ and χ in the Keccak-f round pipeline, and it supports reduced lane widths for Keccak-f[200..1600].

## Interface
- W, 64: lane width in bits. Legal values are 8, 16, 32, 64. Any other value is an elaboration error.
- LPC, 5: lanes rotated per cycle. Legal values are 1, 5, 25. Any other value is an elaboration error.
- Reset is synchronous and active-high.
- clk  in  1  single clock. All logic is on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  unit can accept a state.
- mode  in  2  2'b00 ρ; 2'b01 ρ+π; 2'b10 ρ⁻¹; 2'b11 reserved, behaves as ρ. Sampled only on input handshake.
- A  in  W×5×5  input state, indexed A[x][y] with x,y in 0..4. Sampled only on input handshake.
- out_valid  out  1  A_prime holds a completed result.
- out_ready  in  1  downstream accepts the result.
- A_prime  out  W×5×5  result state, indexed [x][y].
- busy  out  1  high while in BUSY.

## Operation
- Rotation offsets r[x][y], listed as (x,y)=value:
  - (0,0)=0, (1,0)=1, (2,0)=62, (3,0)=28, (4,0)=27
  - (0,1)=36, (1,1)=44, (2,1)=6, (3,1)=55, (4,1)=20
  - (0,2)=3, (1,2)=10, (2,2)=43, (3,2)=25, (4,2)=39
  - (0,3)=41, (1,3)=45, (2,3)=15, (3,3)=21, (4,3)=8
  - (0,4)=18, (1,4)=2, (2,4)=61, (3,4)=56, (4,4)=14
- The effective offset is r mod W.
- ρ is a left rotate, where rotl(v,r)[z] = v[(z−r) mod W]. Each lane is rotated using only its own source lane A[x][y].
- ρ⁻¹ is a right rotate by the same offset.
- ρ+π: the destination is B[y][(2x+3y) mod 5] = rotl(A[x][y], r[x][y]).
- Lane processing order is i = x + 5y, i = 0..24. Group g covers lanes g·LPC .. g·LPC+LPC−1. There are N = 25/LPC groups.
- On input handshake, A and mode are captured into an input register. The output register is written lane-by-lane from the input register, so no hazard arises under π.
- FSM:
  - IDLE: in_ready=1. On in_valid, capture A and mode, clear the group counter g, go to BUSY.
  - BUSY: each cycle, write group g into the output register and increment g. After writing group N−1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready is high only in IDLE. The unit never overlaps states.
- The group counter is ceil(log2 N) bits wide (minimum 1 bit). It never wraps in normal operation.
- A_prime is driven directly from the output register. It must remain stable in DONE while out_ready=0. In IDLE it holds the last result. During BUSY, partially written lanes may be visible, and A_prime is only meaningful when out_valid=1.
- Reset values: in_ready=1, out_valid=0, busy=0, A_prime all zero, g=0, state IDLE.
- rst in any state, including mid-BUSY or DONE with a pending result, discards all work and returns to IDLE on the next edge. rst overrides a simultaneous in_valid or out_ready.
- in_valid and A are ignored outside IDLE.

## Timing
- If the input handshake occurs at edge k, the unit is in BUSY for edges k+1..k+N and out_valid is high after edge k+N.
- Latency is N cycles: 1 for LPC=25, 5 for LPC=5, 25 for LPC=1.
- If the output handshake occurs at edge m ≥ k+N+1, in_ready is high after edge m. The earliest next input handshake is edge m+1.
- Maximum throughput is one state per N+2 cycles.
- The rotator datapath is purely combinational within one cycle: LPC barrel shifts with constant offsets, followed by π muxing.

## Test plan
- Mode ρ, W=64, LPC=5, all lanes 64'h1, out_ready=1 → A_prime[x][y] = 1<<r[x][y]. Check in particular A_prime[1][0]=64'h2, A_prime[2][2]=64'h0000_0800_0000_0000, A_prime[0][0]=64'h1. out_valid is high exactly 5 cycles after accept.
- Lane independence, mode ρ: A[2][2]=64'h1, A[3][2]=64'hFFFF_FFFF_FFFF_FFFF, others 0 → A_prime[2][2]=64'h0000_0800_0000_0000 with no bits from A[3][2], and A_prime[3][2]=all ones.
- Mode ρ+π: A[1][0]=64'h1, rest 0 → A_prime[0][2]=64'h2 and every other lane 0. Mode ρ⁻¹ on the same input → A_prime[1][0]=64'h8000_0000_0000_0000.
- W=8, LPC=25: A[2][0]=8'h01, A[0][1]=8'h01 → A_prime[2][0]=8'h40 (62 mod 8=6) and A_prime[0][1]=8'h10 (36 mod 8=4). out_valid is high 1 cycle after accept.
- Backpressure, LPC=1: hold out_ready=0 for 10 cycles after out_valid rises → A_prime stable, in_ready=0, and in_valid pulses are ignored. Release out_ready → in_ready=1 on the next cycle. Total accept-to-out_valid latency is 25 cycles.
- Reset mid-operation, LPC=1: assert rst for one cycle at group 12 → after that edge, in_ready=1, out_valid=0, busy=0, A_prime=0. A new state accepted afterwards completes correctly in 25 cycles.

Source files
------------

// File: rtl/keccak_rho_pi_unit.sv
// Keccak rho / rho+pi / inverse-rho step unit: captures a 5x5 lane state,
// rotates LPC lanes per cycle into an output register, then holds the result.
module keccak_rho_pi_unit #(
    parameter int unsigned W   = 64,
    parameter int unsigned LPC = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   mode,
    input  logic [4:0][4:0][W-1:0]       A,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4:0][4:0][W-1:0]       A_prime,
    output logic                         busy
);

    localparam int unsigned N  = 25 / LPC;
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = $clog2(W);

    if (!((W == 8) || (W == 16) || (W == 32) || (W == 64))) begin : g_bad_w
        $error("keccak_rho_pi_unit: W must be 8, 16, 32 or 64");
    end
    if (!((LPC == 1) || (LPC == 5) || (LPC == 25))) begin : g_bad_lpc
        $error("keccak_rho_pi_unit: LPC must be 1, 5 or 25");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      w_capture;
    logic                      w_write;
    logic [GW-1:0]             r_g;
    logic [1:0]                r_mode;
    logic [4:0][4:0][W-1:0]    r_a;
    logic [4:0][4:0][W-1:0]    r_a_prime;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic                      r_busy;

    logic [W-1:0]              w_lane [LPC];
    logic [2:0]                w_dx   [LPC];
    logic [2:0]                w_dy   [LPC];

    // Rotation offset for lane index i = x + 5y.
    function automatic int unsigned lane_off(input int unsigned i);
        int unsigned r;
        r = 0;
        case (i)
            0:  r = 0;   1:  r = 1;   2:  r = 62;  3:  r = 28;  4:  r = 27;
            5:  r = 36;  6:  r = 44;  7:  r = 6;   8:  r = 55;  9:  r = 20;
            10: r = 3;   11: r = 10;  12: r = 43;  13: r = 25;  14: r = 39;
            15: r = 41;  16: r = 45;  17: r = 15;  18: r = 21;  19: r = 8;
            20: r = 18;  21: r = 2;   22: r = 61;  23: r = 56;  24: r = 14;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input logic [SW-1:0] amt);
        logic [2*W-1:0] t;
        t = {v, v} << amt;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input logic [SW-1:0] amt);
        logic [2*W-1:0] t;
        t = {v, v} >> amt;
        return t[W-1:0];
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                w_write = 1'b1;
                if (r_g == GW'(N - 1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Per-lane rotate and destination select for the current group.
    always_comb begin
        int unsigned lane_idx;
        logic [2:0]  lane_x;
        logic [2:0]  lane_y;
        logic [SW-1:0] amt;
        lane_idx = 0;
        lane_x   = 3'd0;
        lane_y   = 3'd0;
        amt      = '0;
        for (int j = 0; j < LPC; j++) begin
            lane_idx = int'(r_g) * LPC + j;
            if (lane_idx > 24) begin
                lane_idx = 24;
            end
            lane_x = 3'(lane_idx % 5);
            lane_y = 3'(lane_idx / 5);
            amt    = SW'(lane_off(lane_idx) % W);
            if (r_mode == 2'b10) begin
                w_lane[j] = rotr(r_a[lane_x][lane_y], amt);
            end else begin
                w_lane[j] = rotl(r_a[lane_x][lane_y], amt);
            end
            if (r_mode == 2'b01) begin
                w_dx[j] = lane_y;
                w_dy[j] = 3'((2 * int'(lane_x) + 3 * int'(lane_y)) % 5);
            end else begin
                w_dx[j] = lane_x;
                w_dy[j] = lane_y;
            end
        end
    end

    // Input capture, group counter, output lane writes and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_g         <= '0;
            r_mode      <= 2'b00;
            r_a         <= '0;
            r_a_prime   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_a    <= A;
                r_mode <= mode;
                r_g    <= '0;
            end
            if (w_write) begin
                for (int j = 0; j < LPC; j++) begin
                    r_a_prime[w_dx[j]][w_dy[j]] <= w_lane[j];
                end
                r_g <= r_g + GW'(1);
            end
            r_in_ready  <= (w_next_state == S_IDLE);
            r_out_valid <= (w_next_state == S_DONE);
            r_busy      <= (w_next_state == S_BUSY);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign A_prime   = r_a_prime;

endmodule

// File: tb/tb_keccak_rho_pi_unit.sv
// Bench for keccak_rho_pi_unit: three configurations (W/LPC = 64/5, 8/25, 64/1)
// against a lane-level reference of rho, rho+pi and inverse rho.
module tb_keccak_rho_pi_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    int unsigned roff [5][5] = '{'{0, 36, 3, 41, 18},
                                 '{1, 44, 10, 45, 2},
                                 '{62, 6, 43, 15, 61},
                                 '{28, 55, 25, 21, 56},
                                 '{27, 20, 39, 8, 14}};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar c = 0; c < 3; c++) begin : g_cfg
        localparam int unsigned CW = (c == 1) ? 8 : 64;
        localparam int unsigned CL = (c == 0) ? 5 : ((c == 1) ? 25 : 1);
        localparam int unsigned CN = 25 / CL;
        typedef logic [4:0][4:0][CW-1:0] st_t;

        logic       rst, in_valid, in_ready, out_valid, out_ready, busy;
        logic [1:0] mode;
        st_t        a_in, a_out;

        keccak_rho_pi_unit #(.W(CW), .LPC(CL)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .mode      (mode),
            .A         (a_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .A_prime   (a_out),
            .busy      (busy)
        );

        function automatic st_t ref_fn(input st_t a, input logic [1:0] m);
            st_t b;
            logic [CW-1:0] v, o;
            int r;
            b = '0;
            for (int x = 0; x < 5; x++) begin
                for (int y = 0; y < 5; y++) begin
                    r = int'(roff[x][y] % CW);
                    v = a[x][y];
                    for (int z = 0; z < CW; z++) begin
                        if (m == 2'b10) o[z] = v[(z + r) % CW];
                        else            o[z] = v[(z + CW - r) % CW];
                    end
                    if (m == 2'b01) b[y][(2 * x + 3 * y) % 5] = o;
                    else            b[x][y] = o;
                end
            end
            return b;
        endfunction

        function automatic st_t rand_st();
            st_t s;
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    s[x][y] = CW'({$urandom(), $urandom()});
            return s;
        endfunction

        task automatic cmp_state(input string nm, input st_t act, input st_t exp);
            bit shown;
            shown = 1'b0;
            checks++;
            if (act !== exp) begin
                errors++;
                for (int x = 0; x < 5; x++)
                    for (int y = 0; y < 5; y++)
                        if (!shown && act[x][y] !== exp[x][y]) begin
                            shown = 1'b1;
                            $display("FAIL %s lane[%0d][%0d] got %h expected %h",
                                     nm, x, y, act[x][y], exp[x][y]);
                        end
            end
        endtask

        // Reference model: advanced from the sampled inputs, compared 1 time unit later.
        int  ph = 0;
        int  cnt = 0;
        st_t pend = '0;
        st_t res = '0;
        always @(posedge clk) begin
            if (rst) begin
                ph  = 0;
                res = '0;
            end else if (ph == 0) begin
                if (in_valid) begin
                    pend = ref_fn(a_in, mode);
                    cnt  = CN;
                    ph   = 1;
                end
            end else if (ph == 1) begin
                cnt--;
                if (cnt == 0) begin
                    ph  = 2;
                    res = pend;
                end
            end else if (out_ready) begin
                ph = 0;
            end
            #1;
            check($sformatf("c%0d_in_ready", c), 64'(in_ready), 64'(ph == 0));
            check($sformatf("c%0d_busy", c), 64'(busy), 64'(ph == 1));
            check($sformatf("c%0d_out_valid", c), 64'(out_valid), 64'(ph == 2));
            if (ph != 1) cmp_state($sformatf("c%0d_a_prime", c), a_out, res);
        end

        task automatic do_reset();
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 2'b00; a_in = '0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            check($sformatf("c%0d_rst_in_ready", c), 64'(in_ready), 64'd1);
            check($sformatf("c%0d_rst_out_valid", c), 64'(out_valid), 64'd0);
            check($sformatf("c%0d_rst_busy", c), 64'(busy), 64'd0);
            cmp_state($sformatf("c%0d_rst_a_prime", c), a_out, '0);
        endtask

        task automatic run_txn(input st_t a, input logic [1:0] m, input int hold, output st_t r);
            int t;
            st_t snap;
            t = 0;
            while (!in_ready && t < 200) begin @(negedge clk); t++; end
            check($sformatf("c%0d_accept_ready", c), 64'(in_ready), 64'd1);
            in_valid = 1'b1; a_in = a; mode = m;
            @(negedge clk);
            in_valid = 1'b0; a_in = ~a; mode = ~m;
            t = 0;
            while (!out_valid && t < 100) begin @(negedge clk); t++; end
            check($sformatf("c%0d_latency", c), 64'(t), 64'(CN));
            snap = a_out;
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1; a_in = rand_st();
                @(negedge clk);
            end
            in_valid = 1'b0;
            if (hold > 0) begin
                cmp_state($sformatf("c%0d_hold_stable", c), a_out, snap);
                check($sformatf("c%0d_hold_in_ready", c), 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check($sformatf("c%0d_release_in_ready", c), 64'(in_ready), 64'd1);
            check($sformatf("c%0d_release_out_valid", c), 64'(out_valid), 64'd0);
            r = a_out;
        endtask

        task automatic run_random(input int n);
            st_t a, r;
            logic [1:0] m;
            for (int k = 0; k < n; k++) begin
                a = rand_st();
                m = 2'($urandom_range(0, 3));
                run_txn(a, m, int'($urandom_range(0, 3)), r);
                cmp_state($sformatf("c%0d_rand_result", c), r, ref_fn(a, m));
            end
        endtask

        if (c == 0) begin : g_dir
            initial begin
                st_t a, r, e;
                do_reset();
                a = '0;
                for (int x = 0; x < 5; x++)
                    for (int y = 0; y < 5; y++)
                        a[x][y] = CW'(1);
                run_txn(a, 2'b00, 0, r);
                check("c0_rho_ones_10", 64'(r[1][0]), 64'h2);
                check("c0_rho_ones_22", 64'(r[2][2]), 64'h0000_0800_0000_0000);
                check("c0_rho_ones_00", 64'(r[0][0]), 64'h1);
                check("c0_rho_ones_44", 64'(r[4][4]), 64'h4000);
                a = '0; a[2][2] = CW'(1); a[3][2] = '1;
                run_txn(a, 2'b00, 2, r);
                check("c0_indep_22", 64'(r[2][2]), 64'h0000_0800_0000_0000);
                check("c0_indep_32", 64'(r[3][2]), 64'hFFFF_FFFF_FFFF_FFFF);
                a = '0; a[1][0] = CW'(1);
                run_txn(a, 2'b01, 1, r);
                e = '0; e[0][2] = CW'(2);
                check("c0_pi_02", 64'(r[0][2]), 64'h2);
                cmp_state("c0_pi_whole", r, e);
                run_txn(a, 2'b10, 0, r);
                check("c0_inv_10", 64'(r[1][0]), 64'h8000_0000_0000_0000);
                run_txn(a, 2'b11, 0, r);
                check("c0_reserved_10", 64'(r[1][0]), 64'h2);
                in_valid = 1'b1; a_in = rand_st(); rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; in_valid = 1'b0;
                check("c0_rst_over_valid_ready", 64'(in_ready), 64'd1);
                check("c0_rst_over_valid_busy", 64'(busy), 64'd0);
                cmp_state("c0_rst_over_valid_zero", a_out, '0);
                run_random(10);
                n_done++;
            end
        end else if (c == 1) begin : g_dir
            initial begin
                st_t a, r;
                do_reset();
                a = '0; a[2][0] = CW'(1); a[0][1] = CW'(1);
                run_txn(a, 2'b00, 2, r);
                check("c1_rho_20", 64'(r[2][0]), 64'h40);
                check("c1_rho_01", 64'(r[0][1]), 64'h10);
                run_random(10);
                n_done++;
            end
        end else begin : g_dir
            initial begin
                st_t a, r;
                int t;
                do_reset();
                a = rand_st();
                run_txn(a, 2'b01, 10, r);
                cmp_state("c2_bp_result", r, ref_fn(a, 2'b01));
                // Abort while group 12 is about to be written.
                t = 0;
                while (!in_ready && t < 200) begin @(negedge clk); t++; end
                in_valid = 1'b1; a_in = rand_st(); mode = 2'b00;
                @(negedge clk);
                in_valid = 1'b0;
                repeat (12) @(negedge clk);
                check("c2_mid_busy_before_rst", 64'(busy), 64'd1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("c2_mid_rst_in_ready", 64'(in_ready), 64'd1);
                check("c2_mid_rst_out_valid", 64'(out_valid), 64'd0);
                check("c2_mid_rst_busy", 64'(busy), 64'd0);
                cmp_state("c2_mid_rst_zero", a_out, '0);
                a = rand_st();
                run_txn(a, 2'b00, 1, r);
                cmp_state("c2_after_rst_result", r, ref_fn(a, 2'b00));
                run_random(6);
                n_done++;
            end
        end
    end

    initial begin
        fork
            wait (n_done == 3);
            #500_000;
        join_any
        disable fork;
        if (n_done != 3) check("timeout_done_count", 64'(n_done), 64'd3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
